// File: rtl/sd_dat_tx_ctrl.sv
// sd_dat_tx_ctrl: sequences one SD write data block on the DAT lines.
//   Serializes bytes from a valid/ready stream in 1-bit or 4-bit mode,
//   frames them with a start bit, per-lane CRC16 and an end bit, then
//   collects the card's CRC-status token and (optionally) waits out busy.
// Ports:
//   sdClk, sdRst             clock, synchronous active-high reset
//   start, wide_bus          block request (idle only), bus width at accept
//   byte_in/valid/ready      byte stream, consumed when valid && ready
//   crc_rst/en/in, crc_out   control of / results from four CRC16 lane units
//   dat_out, dat_oe, dat_in  DAT line drive, enable and sampled lines
//   busy, done, err_code     status; err 00 ok, 01 crc neg, 10 timeout, 11 underrun
//   crc_status               last received status token
// Build option: define SD_TX_BUSY_WAIT_EN to monitor DAT0 busy after a
//   positive status token (bounded by BUSY_TIMEOUT).
module sd_dat_tx_ctrl #(
    parameter int unsigned BLOCK_BYTES  = 512,
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter int unsigned BUSY_TIMEOUT = 65535
) (
    input  logic        sdClk,
    input  logic        sdRst,
    input  logic        start,
    input  logic        wide_bus,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        crc_rst,
    output logic        crc_en,
    output logic [3:0]  crc_in,
    input  logic [63:0] crc_out,
    output logic [3:0]  dat_out,
    output logic        dat_oe,
    input  logic [3:0]  dat_in,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [2:0]  crc_status
);

    localparam int unsigned BYTE_W  = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam int unsigned CNT_MAX0 = (BUSY_TIMEOUT > RESP_TIMEOUT) ? BUSY_TIMEOUT : RESP_TIMEOUT;
    localparam int unsigned CNT_MAX = (CNT_MAX0 > 16) ? CNT_MAX0 : 16;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_PRE, ST_START, ST_DATA, ST_CRC, ST_END,
        ST_TURN, ST_RESP, ST_STAT, ST_BUSY, ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               wide_q, wide_d;
    logic [7:0]         byte_q, byte_d;
    logic [2:0]         bit_q, bit_d;
    logic [BYTE_W-1:0]  bcnt_q, bcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;
    logic [2:0]         status_q, status_d;

    logic [3:0][15:0]   crc_lane;
    logic [3:0]         crc_idx;
    logic [3:0]         crc_bits;
    logic [3:0]         lane_mask;
    logic [3:0]         data_bits;
    logic               last_bit;
    logic               unused_dat;

    // Only DAT0 carries the card's response.
    assign unused_dat = ^dat_in[3:1];

    // Per-cycle line values for the DATA and CRC phases; unused lanes idle high.
    assign crc_lane  = crc_out;
    assign crc_idx   = 4'd15 - cnt_q[3:0];
    assign crc_bits  = wide_q ? {crc_lane[3][crc_idx], crc_lane[2][crc_idx],
                                 crc_lane[1][crc_idx], crc_lane[0][crc_idx]}
                              : {3'b111, crc_lane[0][crc_idx]};
    assign lane_mask = wide_q ? 4'hF : 4'h1;
    assign data_bits = wide_q ? (bit_q[0] ? byte_q[3:0] : byte_q[7:4])
                              : {3'b111, byte_q[3'd7 - bit_q]};
    assign last_bit  = wide_q ? (bit_q == 3'd1) : (bit_q == 3'd7);

    assign busy       = (state_q != ST_IDLE);
    assign err_code   = err_q;
    assign crc_status = status_q;

    // State and datapath registers.
    always_ff @(posedge sdClk) begin
        if (sdRst) begin
            state_q  <= ST_IDLE;
            wide_q   <= 1'b0;
            byte_q   <= 8'h00;
            bit_q    <= 3'd0;
            bcnt_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 2'b00;
            status_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            wide_q   <= wide_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            bcnt_q   <= bcnt_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            status_q <= status_d;
        end
    end

    // Next-state and line/CRC control decode.
    always_comb begin
        state_d    = state_q;
        wide_d     = wide_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        bcnt_d     = bcnt_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        status_d   = status_q;
        byte_ready = 1'b0;
        crc_rst    = 1'b0;
        crc_en     = 1'b0;
        crc_in     = 4'h0;
        dat_out    = 4'hF;
        dat_oe     = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_PRE;
                    wide_d   = wide_bus;
                    err_d    = 2'b00;
                    status_d = 3'b000;
                end
            end
            ST_PRE: begin
                dat_oe  = 1'b1;
                crc_rst = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                dat_oe     = 1'b1;
                dat_out    = ~lane_mask;
                byte_ready = 1'b1;
                bit_d      = 3'd0;
                bcnt_d     = '0;
                if (byte_valid) begin
                    byte_d  = byte_in;
                    state_d = ST_DATA;
                end else begin
                    dat_oe  = 1'b0;
                    err_d   = 2'b11;
                    state_d = ST_DONE;
                end
            end
            ST_DATA: begin
                dat_oe  = 1'b1;
                dat_out = data_bits;
                crc_en  = 1'b1;
                crc_in  = wide_q ? data_bits : {3'b000, data_bits[0]};
                if (!last_bit) begin
                    bit_d = bit_q + 3'd1;
                end else if (bcnt_q == BYTE_W'(BLOCK_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CRC;
                end else begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        byte_d = byte_in;
                        bit_d  = 3'd0;
                        bcnt_d = bcnt_q + BYTE_W'(1);
                    end else begin
                        // Underrun: release the bus and keep the CRC units frozen.
                        dat_oe  = 1'b0;
                        crc_en  = 1'b0;
                        crc_in  = 4'h0;
                        err_d   = 2'b11;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CRC: begin
                dat_oe  = 1'b1;
                dat_out = crc_bits;
                if (cnt_q[3:0] == 4'd15) begin
                    state_d = ST_END;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_END: begin
                dat_oe  = 1'b1;
                cnt_d   = '0;
                state_d = ST_TURN;
            end
            ST_TURN: begin
                if (cnt_q[0]) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (!dat_in[0]) begin
                    cnt_d   = '0;
                    state_d = ST_STAT;
                end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
                    err_d   = 2'b10;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STAT: begin
                // Three token bits MSB first, then one end-bit cycle.
                if (cnt_q[1:0] != 2'd3) begin
                    status_d = {status_q[1:0], dat_in[0]};
                    cnt_d    = cnt_q + CNT_W'(1);
                end else if (status_q == 3'b010) begin
`ifdef SD_TX_BUSY_WAIT_EN
                    cnt_d   = '0;
                    state_d = ST_BUSY;
`else
                    err_d   = 2'b00;
                    state_d = ST_DONE;
`endif
                end else begin
                    err_d   = 2'b01;
                    state_d = ST_DONE;
                end
            end
`ifdef SD_TX_BUSY_WAIT_EN
            ST_BUSY: begin
                if (dat_in[0]) begin
                    err_d   = 2'b00;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 2'b10;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_dat_tx_ctrl.sv
// tb_sd_dat_tx_ctrl: directed bench for sd_dat_tx_ctrl with a 4-byte block,
// behavioural CRC16 lane units and a scripted card on DAT0.
module tb_sd_dat_tx_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned RT = 64;
    localparam int unsigned BT = 40;

    logic        sdClk = 1'b0;
    logic        sdRst;
    logic        start;
    logic        wide_bus;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        crc_rst;
    logic        crc_en;
    logic [3:0]  crc_in;
    logic [63:0] crc_out;
    logic [3:0]  dat_out;
    logic        dat_oe;
    logic [3:0]  dat_in;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [2:0]  crc_status;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  tx_bytes [NB];
    int          feed_idx = 0;
    int          drop_idx = -1;
    logic [15:0] lane_crc [4] = '{default: 16'h0000};

    always #5 sdClk = ~sdClk;

    sd_dat_tx_ctrl #(
        .BLOCK_BYTES (NB),
        .RESP_TIMEOUT(RT),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .sdClk     (sdClk),
        .sdRst     (sdRst),
        .start     (start),
        .wide_bus  (wide_bus),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .crc_rst   (crc_rst),
        .crc_en    (crc_en),
        .crc_in    (crc_in),
        .crc_out   (crc_out),
        .dat_out   (dat_out),
        .dat_oe    (dat_oe),
        .dat_in    (dat_in),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code),
        .crc_status(crc_status)
    );

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Byte source: stalls (valid low) once drop_idx bytes have been taken.
    assign byte_in    = (feed_idx < int'(NB)) ? tx_bytes[2'(feed_idx)] : 8'h00;
    assign byte_valid = (feed_idx != drop_idx);

    always @(posedge sdClk) begin
        if (start && !busy) feed_idx <= 0;
        else if (byte_ready && byte_valid) feed_idx <= feed_idx + 1;
    end

    // External CRC16 lane units (poly 0x1021, cleared to zero).
    always @(posedge sdClk) begin
        for (int i = 0; i < 4; i++) begin
            if (crc_rst) lane_crc[i] <= 16'h0000;
            else if (crc_en) lane_crc[i] <= crc_step(lane_crc[i], crc_in[i]);
        end
    end
    assign crc_out = {lane_crc[3], lane_crc[2], lane_crc[1], lane_crc[0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},     32'(busy),       32'd0);
        check({tag, "_done"},     32'(done),       32'd0);
        check({tag, "_err"},      32'(err_code),   32'd0);
        check({tag, "_status"},   32'(crc_status), 32'd0);
        check({tag, "_oe"},       32'(dat_oe),     32'd0);
        check({tag, "_dat"},      32'(dat_out),    32'hF);
        check({tag, "_crc_ctl"},  32'({crc_rst, crc_en}), 32'd0);
        check({tag, "_ready"},    32'(byte_ready), 32'd0);
    endtask

    // Bit carried by a lane in data cycle n of the current block.
    function automatic logic lane_bit(input logic wide, input int lane, input int n);
        logic [7:0] b;
        if (wide) begin
            b = tx_bytes[2'(n / 2)];
            return (n % 2 == 0) ? b[3'(4 + lane)] : b[3'(lane)];
        end
        b = tx_bytes[2'(n / 8)];
        return (lane == 0) ? b[3'(7 - n % 8)] : 1'b0;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge sdClk);
            start  = 1'b0;
            dat_in = 4'hF;
        end
    endtask

    // Runs one block. resp_dly < 0: card never answers; drop >= 0: stream stalls
    // before that byte index. All expectations come from these arguments.
    task automatic run_block(input string name, input logic wide, input int resp_dly,
                             input logic [2:0] status, input int busy_cyc, input int drop);
        int L, N, E, s, exp_done, abort_c, c, done_c, bad_data, bad_crc, bad_oe, en_cnt, k;
        logic [1:0]  exp_err;
        logic [1:0]  done_err;
        logic [2:0]  exp_status;
        logic [3:0]  exp_line;
        logic        card;
        logic [15:0] exp_crc [4];

        L = wide ? 4 : 1;
        N = 8 * int'(NB) / L;
        E = 19 + N;
        s = E + 3 + resp_dly;
        drop_idx = drop;
        exp_status = 3'b000;
        abort_c = 1 << 30;
        if (drop >= 0) begin
            abort_c  = 2 + drop * (8 / L);
            exp_done = abort_c + 1;
            exp_err  = 2'b11;
        end else if (resp_dly < 0) begin
            exp_done = E + 3 + int'(RT);
            exp_err  = 2'b10;
        end else begin
            exp_status = status;
            if (status != 3'b010) begin
                exp_done = s + 5;
                exp_err  = 2'b01;
            end else begin
`ifdef SD_TX_BUSY_WAIT_EN
                if (busy_cyc >= int'(BT)) begin
                    exp_done = s + 5 + int'(BT);
                    exp_err  = 2'b10;
                end else begin
                    exp_done = s + 6 + busy_cyc;
                    exp_err  = 2'b00;
                end
`else
                exp_done = s + 5;
                exp_err  = 2'b00;
`endif
            end
        end

        for (int i = 0; i < 4; i++) begin
            exp_crc[i] = 16'h0000;
            for (int n = 0; n < N; n++) exp_crc[i] = crc_step(exp_crc[i], lane_bit(wide, i, n));
        end

        done_c = -1; done_err = 2'b00;
        bad_data = 0; bad_crc = 0; bad_oe = 0; en_cnt = 0;
        c = 0;
        while (c < exp_done + 10 && done_c < 0) begin
            @(negedge sdClk);
            start    = (c == 0) || (c == 5);
            wide_bus = (c == 0) ? wide : ~wide;
            card = 1'b1;
            if (resp_dly >= 0) begin
                if (c == s) card = 1'b0;
                else if (c > s && c <= s + 3) card = status[2'(s + 3 - c)];
                else if (c >= s + 5 && c < s + 5 + busy_cyc) card = 1'b0;
            end
            dat_in = {3'b111, card};
            #1;
            if (crc_en) en_cnt++;
            if (c == 1) begin
                check({name, "_pre_oe"},  32'(dat_oe),  32'd1);
                check({name, "_pre_dat"}, 32'(dat_out), 32'hF);
                check({name, "_pre_rst"}, 32'(crc_rst), 32'd1);
            end
            if (c == 2 && drop != 0) begin
                check({name, "_startbit"}, 32'({dat_oe, dat_out}), wide ? 32'h10 : 32'h1E);
            end
            if (c >= 3 && c < 3 + N && c < abort_c) begin
                k = c - 3;
                exp_line = wide ? {lane_bit(1'b1, 3, k), lane_bit(1'b1, 2, k),
                                   lane_bit(1'b1, 1, k), lane_bit(1'b1, 0, k)}
                                : {3'b111, lane_bit(1'b0, 0, k)};
                if (dat_out !== exp_line || dat_oe !== 1'b1) bad_data++;
            end
            if (drop < 0 && c >= 3 + N && c < E) begin
                k = 15 - (c - 3 - N);
                exp_line = wide ? {exp_crc[3][4'(k)], exp_crc[2][4'(k)],
                                   exp_crc[1][4'(k)], exp_crc[0][4'(k)]}
                                : {3'b111, exp_crc[0][4'(k)]};
                if (dat_out !== exp_line || dat_oe !== 1'b1) bad_crc++;
            end
            if (drop < 0 && c == E) check({name, "_endbit"}, 32'({dat_oe, dat_out}), 32'h1F);
            if (drop < 0 && c == E + 1) check({name, "_turn_oe"}, 32'(dat_oe), 32'd0);
            if (drop >= 0 && c == abort_c)
                check({name, "_abort_oe_en"}, 32'({dat_oe, crc_en}), 32'd0);
            if (drop >= 0 && c >= abort_c && dat_oe) bad_oe++;
            if (done) begin
                done_c   = c;
                done_err = err_code;
            end
            c++;
        end
        start = 1'b0;
        dat_in = 4'hF;

        check({name, "_done_cycle"}, 32'(done_c), 32'(exp_done));
        check({name, "_err"}, 32'(done_err), 32'(exp_err));
        check({name, "_crc_en_cycles"}, 32'(en_cnt), (drop >= 0) ? 32'(abort_c - 3) : 32'(N));
        if (drop < 0) begin
            check({name, "_data"}, 32'(bad_data), 32'd0);
            check({name, "_crc"},  32'(bad_crc),  32'd0);
        end else begin
            check({name, "_data"},      32'(bad_data), 32'd0);
            check({name, "_no_tx_after"}, 32'(bad_oe), 32'd0);
        end
        @(negedge sdClk);
        #1;
        check({name, "_after_done"}, 32'({busy, done}), 32'd0);
        check({name, "_err_hold"},   32'(err_code),     32'(exp_err));
        check({name, "_status"},     32'(crc_status),   32'(exp_status));
    endtask

    initial begin
        sdRst    = 1'b1;
        start    = 1'b0;
        wide_bus = 1'b0;
        dat_in   = 4'hF;
        repeat (2) @(negedge sdClk);
        #1;
        check_idle("reset");
        sdRst = 1'b0;
        idle_cycles(2);

        tx_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_block("w1_ff", 1'b0, 2, 3'b010, 5, -1);
        idle_cycles(2);

        tx_bytes = '{8'h01, 8'h23, 8'h45, 8'h67};
        run_block("w4_seq", 1'b1, 0, 3'b010, 0, -1);
        idle_cycles(2);

        run_block("w4_neg", 1'b1, 1, 3'b101, 0, -1);
        idle_cycles(2);

        run_block("w4_drop", 1'b1, 0, 3'b010, 0, 2);
        // Reset while idle clears the held error code.
        @(negedge sdClk);
        sdRst = 1'b1;
        @(negedge sdClk);
        sdRst = 1'b0;
        #1;
        check_idle("idle_rst");
        idle_cycles(1);

        tx_bytes = '{8'h80, 8'h01, 8'hFE, 8'h7F};
        run_block("w1_noresp", 1'b0, -1, 3'b000, 0, -1);
        idle_cycles(2);

        run_block("w4_stuck", 1'b1, 3, 3'b010, 1000, -1);
        idle_cycles(2);

        // Reset in the middle of DATA, then a clean block with new data.
        drop_idx = -1;
        @(negedge sdClk);
        start = 1'b1;
        wide_bus = 1'b1;
        repeat (4) begin
            @(negedge sdClk);
            start = 1'b0;
        end
        sdRst = 1'b1;
        @(negedge sdClk);
        sdRst = 1'b0;
        #1;
        check_idle("mid_rst");
        idle_cycles(1);
        tx_bytes = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
        run_block("w4_after_rst", 1'b1, 4, 3'b010, 2, -1);
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sd_dat_tx_ctrl.md
Name: sd_dat_tx_ctrl

Overview:
Sequencer for one SD write data block on the DAT lines, in 1-bit or 4-bit bus mode.
- Transmit side: takes bytes over a valid/ready stream, serializes them, and frames the block with start bit, data, per-lane CRC16 and end bit.
- CRC control: drives four external CRC16 lane units (clear/enable/data bit) and reads back their 16-bit results.
- Receive side: after the block, samples the card's CRC-status token and busy signal on DAT0, then reports completion and an error code to the host-side controller.

Parameters:
- BLOCK_BYTES, 512: bytes per data block (range 1..4096).
- RESP_TIMEOUT, 64: max sdClk cycles from end bit to CRC-status start bit.
- BUSY_TIMEOUT, 65535: max sdClk cycles DAT0 may stay low in busy.

Ports:
- sdClk  in  1  SD bit clock; all logic on rising edge.
- sdRst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to send one block; ignored unless idle.
- wide_bus  in  1  1 = 4-bit bus, 0 = 1-bit; sampled when start is accepted.
- byte_in  in  8  data byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  byte consumed this cycle when byte_valid is also high.
- crc_rst  out  1  clear for all CRC lane units.
- crc_en  out  1  advance enable for all CRC lane units.
- crc_in  out  4  bit i feeds CRC lane unit i.
- crc_out  in  64  lane i result on bits [16i+15:16i].
- dat_out  out  4  DAT line drive values.
- dat_oe  out  1  DAT output enable.
- dat_in  in  4  sampled DAT lines; only bit 0 is used.
- busy  out  1  high in any state except IDLE.
- done  out  1  single-cycle completion pulse.
- err_code  out  2  valid when done is high: 00 ok, 01 CRC-status negative, 10 timeout, 11 data underrun.
- crc_status  out  3  last received status token, held until the next start.

Behaviour:
- Clock/reset: one clock, sdClk. sdRst is synchronous and active-high, and overrides everything, including mid-block. Reset values:
  - state IDLE; busy 0, done 0, err_code 00, crc_status 000;
  - dat_oe 0, dat_out 4'hF, crc_rst 0, crc_en 0, byte_ready 0.
- Lane count L = 4 if wide_bus else 1. In 1-bit mode dat_out[3:1] = 1 and crc_in[3:1] = 0.
- IDLE: start → PRE next cycle.
- PRE (1 cycle): dat_oe = 1, dat_out = F, crc_rst = 1.
- START (1 cycle): dat_out lanes < L = 0.
  - byte_ready = 1 to load the first byte.
  - byte_valid = 0 here → underrun abort.
- DATA: 1-bit mode sends one bit per cycle on DAT0, MSB first (8 cycles/byte). 4-bit mode sends DAT[3:0] = byte[7:4], then byte[3:0] (2 cycles/byte).
  - crc_en = 1 and crc_in = dat_out for every DATA cycle only.
  - On the last bit cycle of each byte except the final one, byte_ready = 1 and the next byte loads. byte_valid = 0 there → underrun abort.
  - Byte counter 0..BLOCK_BYTES-1; after the last bit of byte BLOCK_BYTES-1 → CRC.
- CRC (16 cycles): crc_en = 0, so lane values stay frozen. Lane i drives crc_out[16i+15-k] in cycle k (MSB first).
- END (1 cycle): lanes < L = 1, then → TURN.
- TURN (2 cycles): dat_oe = 0, then → RESP.
- RESP: wait for dat_in[0] = 0 (start bit).
  - Capture the next 3 bits, MSB first, into crc_status, then consume 1 end-bit cycle.
  - crc_status == 3'b010 → BUSY; otherwise DONE with err 01.
  - Start bit not seen within RESP_TIMEOUT cycles after TURN → DONE with err 10.
- BUSY: wait for dat_in[0] = 1 → DONE with err 00; BUSY_TIMEOUT cycles elapsed → DONE with err 10. The counter restarts on entering BUSY.
- DONE (1 cycle): done = 1, err_code valid → IDLE. err_code holds until the next start.
- Underrun abort: in the same cycle dat_oe = 0, crc_en = 0, next state DONE with err 11.
- Latency: start accepted at cycle t → start bit on the lines at t+2. End bit at t + 3 + 8·BLOCK_BYTES/L + 16.
- Simultaneous events: start during non-IDLE is ignored. byte_valid outside byte_ready cycles is ignored.

Optional Feature:
SD_TX_BUSY_WAIT_EN
- Defined: BUSY state and BUSY_TIMEOUT as above.
- Undefined: a 010 status goes directly to DONE with err 00. DAT0 busy is not monitored, and BUSY_TIMEOUT is unused.

Test Plan:
- 1-bit, BLOCK_BYTES=512, all bytes 0xFF, card answers 010 then 5 busy cycles → DAT0 shows start 0, 4096 ones, CRC 0x7FA1, end 1. crc_status 010, done with err 00.
- 4-bit, BLOCK_BYTES=4, bytes 01 23 45 67 → DAT[3:0] sequence 0,1,2,3,4,5,6,7. crc_en high exactly 8 cycles. Per-lane CRC matches model. End bit at t+27.
- 4-bit, card status 101 → done with err 01, crc_status 101, BUSY skipped.
- byte_valid dropped on byte 2 of 4 → dat_oe low in the next cycle, done with err 11, no CRC or end bit sent.
- No start bit from card (DAT0 held 1) with RESP_TIMEOUT=64 → done with err 10 exactly 64 cycles after TURN. Repeat with DAT0 stuck low in BUSY for BUSY_TIMEOUT → err 10.
- sdRst asserted mid-DATA, then start reissued → all outputs at reset values the next cycle; second block sent correctly with fresh CRC (crc_rst seen in PRE).
